// File: rtl/block_serial_subtractor_if.sv
// Operand/result handshake bundle for the block-serial subtractor.
// The upstream/downstream side uses the master modport and the subtractor uses the slave modport.
interface block_serial_subtractor_if #(
    parameter int N = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/block_serial_subtractor.sv
// Multi-cycle subtractor computing a - b - bin one BLOCK_SIZE-bit block per clock, LSB first.
// The borrow between blocks is carried in a register, and the result is held until the consumer takes it.
module block_serial_subtractor #(
    parameter int N          = 8,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    block_serial_subtractor_if.slave    bus
);
    localparam int NUM_BLOCKS = (N + BLOCK_SIZE - 1) / BLOCK_SIZE;
    localparam int W          = NUM_BLOCKS * BLOCK_SIZE;
    localparam int IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q;
    logic [W-1:0]            a_q, b_q, acc_q;
    logic                    borrow_q;
    logic [IDX_W-1:0]        idx_q;
    logic [N-1:0]            diff_q;
    logic                    bout_q, ovf_q;
    logic                    in_ready_q, out_valid_q;

    logic [W-1:0]            a_ext, b_ext, acc_d;
    logic [BLOCK_SIZE-1:0]   a_blk, b_blk;
    logic [BLOCK_SIZE:0]     blk_diff;
    logic                    last_blk;
    int                      ofs;

    // Zero-extended operands make the top block uniform; its extra bits never reach diff.
    always_comb begin
        a_ext    = W'(bus.a);
        b_ext    = W'(bus.b);
        ofs      = int'(idx_q) * BLOCK_SIZE;
        a_blk    = a_q[ofs +: BLOCK_SIZE];
        b_blk    = b_q[ofs +: BLOCK_SIZE];
        blk_diff = {1'b0, a_blk} - {1'b0, b_blk} - (BLOCK_SIZE + 1)'(borrow_q);
        acc_d    = acc_q;
        acc_d[ofs +: BLOCK_SIZE] = blk_diff[BLOCK_SIZE-1:0];
        last_blk = (idx_q == IDX_W'(NUM_BLOCKS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            borrow_q    <= 1'b0;
            idx_q       <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= a_ext;
                        b_q        <= b_ext;
                        borrow_q   <= bus.bin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    borrow_q <= blk_diff[BLOCK_SIZE];
                    if (last_blk) begin
                        // Borrow out of the padded top bit equals the borrow out of bit N-1.
                        diff_q      <= acc_d[N-1:0];
                        bout_q      <= blk_diff[BLOCK_SIZE];
                        ovf_q       <= (a_q[N-1] ^ b_q[N-1]) & (a_q[N-1] ^ acc_d[N-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_block_serial_subtractor.sv
// Scoreboard bench: one instance with N=8/BS=4 and one with N=1/BS=3, each checked against an arithmetic model.
module tb_block_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    block_serial_subtractor_if #(.N(8)) ia ();
    block_serial_subtractor_if #(.N(1)) ib ();

    block_serial_subtractor #(.N(8), .BLOCK_SIZE(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    block_serial_subtractor #(.N(1), .BLOCK_SIZE(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        exp_t r;
        int full, sr;
        full = int'(a) - int'(b) - int'(bin);
        sr   = int'($signed(a)) - int'($signed(b)) - int'(bin);
        r.d  = 8'(full);
        r.bo = (full < 0);
        r.ov = (sr < -128) || (sr > 127);
        return r;
    endfunction

    function automatic exp_t model1(input logic a, input logic b, input logic bin);
        exp_t r;
        int full, sa, sb, sr;
        full = int'(a) - int'(b) - int'(bin);
        sa   = a ? -1 : 0;
        sb   = b ? -1 : 0;
        sr   = sa - sb - int'(bin);
        r.d  = {7'b0, 1'(full)};
        r.bo = (full < 0);
        r.ov = (sr < -1) || (sr > 0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ia.out_valid === 1'b1 && ia.out_ready === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_result", 32'(ia.out_valid), 32'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_diff", 32'(ia.diff), 32'(e.d));
                chk("a_bout", 32'(ia.bout), 32'(e.bo));
                chk("a_ovf", 32'(ia.ovf), 32'(e.ov));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ib.out_valid === 1'b1 && ib.out_ready === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_result", 32'(ib.out_valid), 32'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_diff", 32'(ib.diff), 32'(e.d));
                chk("b_bout", 32'(ib.bout), 32'(e.bo));
                chk("b_ovf", 32'(ib.ovf), 32'(e.ov));
            end
        end
    end

    task automatic send_a(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit track);
        int n = 0;
        ia.a = a; ia.b = b; ia.bin = bin; ia.in_valid = 1'b1;
        while (ia.in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("a_ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        if (track) qa.push_back(model8(a, b, bin));
        #1 ia.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic a, input logic b, input logic bin);
        int n = 0;
        ib.a = a; ib.b = b; ib.bin = bin; ib.in_valid = 1'b1;
        while (ib.in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("b_ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        qb.push_back(model1(a, b, bin));
        #1 ib.in_valid = 1'b0;
    endtask

    task automatic wait_valid_a(output int lat);
        lat = 0;
        while (ia.out_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        if (lat >= 50) chk("a_valid_timeout", 32'(ia.out_valid), 32'd1);
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (ia.out_valid !== 1'b0 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("a_idle_timeout", 32'(ia.out_valid), 32'd0);
    endtask

    task automatic run_b(input logic a, input logic b, input logic bin, output int lat);
        int n = 0;
        send_b(a, b, bin);
        lat = 0;
        while (ib.out_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        if (lat >= 50) chk("b_valid_timeout", 32'(ib.out_valid), 32'd1);
        while (ib.out_valid !== 1'b0 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("b_idle_timeout", 32'(ib.out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        logic [7:0] hd;
        logic hb, ho;
        ia.in_valid = 1'b0; ia.a = '0; ia.b = '0; ia.bin = 1'b0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.a = '0; ib.b = '0; ib.bin = 1'b0; ib.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(ia.in_ready), 32'd1);
        chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
        chk("rst_diff", 32'(ia.diff), 32'd0);
        chk("rst_bout", 32'(ia.bout), 32'd0);
        chk("rst_ovf", 32'(ia.ovf), 32'd0);
        chk("rst_b_in_ready", 32'(ib.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed N=8 cases with literal expectations.
        send_a(8'h35, 8'h12, 1'b0, 1'b1);
        wait_valid_a(lat);
        chk("t1_latency", 32'(lat), 32'd2);
        chk("t1_diff", 32'(ia.diff), 32'h23);
        chk("t1_bout", 32'(ia.bout), 32'd0);
        chk("t1_ovf", 32'(ia.ovf), 32'd0);
        wait_idle_a();

        send_a(8'h00, 8'h01, 1'b0, 1'b1);
        wait_valid_a(lat);
        chk("t2_diff", 32'(ia.diff), 32'hFF);
        chk("t2_bout", 32'(ia.bout), 32'd1);
        chk("t2_ovf", 32'(ia.ovf), 32'd0);
        wait_idle_a();

        send_a(8'h80, 8'h01, 1'b1, 1'b1);
        wait_valid_a(lat);
        chk("t3_diff", 32'(ia.diff), 32'h7E);
        chk("t3_bout", 32'(ia.bout), 32'd0);
        chk("t3_ovf", 32'(ia.ovf), 32'd1);
        wait_idle_a();

        // N=1 full sweep; a few combinations also checked against literals.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run_b(v[2], v[1], v[0], lat);
            chk("t4_latency", 32'(lat), 32'd1);
            if (v == 3'b011) begin
                chk("t4_011_diff", 32'(ib.diff), 32'd0);
                chk("t4_011_bout", 32'(ib.bout), 32'd1);
            end
            if (v == 3'b111) begin
                chk("t4_111_diff", 32'(ib.diff), 32'd1);
                chk("t4_111_bout", 32'(ib.bout), 32'd1);
            end
        end

        // Backpressure: results hold and new operands are ignored while stalled.
        ia.out_ready = 1'b0;
        send_a(8'hC3, 8'h5A, 1'b1, 1'b1);
        wait_valid_a(lat);
        hd = ia.diff; hb = ia.bout; ho = ia.ovf;
        ia.a = 8'hFF; ia.b = 8'h01; ia.bin = 1'b0; ia.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("t5_diff_stable", 32'(ia.diff), 32'(hd));
            chk("t5_bout_stable", 32'(ia.bout), 32'(hb));
            chk("t5_ovf_stable", 32'(ia.ovf), 32'(ho));
            chk("t5_in_ready", 32'(ia.in_ready), 32'd0);
            chk("t5_out_valid", 32'(ia.out_valid), 32'd1);
        end
        ia.in_valid = 1'b0;
        ia.out_ready = 1'b1;
        wait_idle_a();
        repeat (3) begin
            @(posedge clk); #1;
            chk("t5_no_extra", 32'(ia.out_valid), 32'd0);
        end

        // Reset mid-RUN discards the operation.
        send_a(8'h55, 8'h33, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 32'(ia.out_valid), 32'd0);
        chk("t6_rst_in_ready", 32'(ia.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_a(8'hA0, 8'h0A, 1'b0, 1'b1);
        wait_valid_a(lat);
        chk("t6_latency", 32'(lat), 32'd2);
        chk("t6_diff", 32'(ia.diff), 32'h96);
        wait_idle_a();

        // Random operands with random consumer stalls.
        for (int i = 0; i < 40; i++) begin
            int k;
            send_a(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            wait_valid_a(lat);
            k = int'($urandom_range(0, 3));
            if (k > 0) begin
                ia.out_ready = 1'b0;
                repeat (k) begin @(posedge clk); #1; end
                ia.out_ready = 1'b1;
            end
            wait_idle_a();
        end

        repeat (4) @(posedge clk);
        #1;
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
